uart_tx_fifo_reader: RTL and testbench
======================================

# uart_tx_fifo_reader

Serial UART transmitter that drains the transmit FIFO and drives the TX line. It pops one word whenever the FIFO is non-empty and transmission is enabled. Each word is sent as a frame: start bit, DATA_SIZE data bits (LSB first), an optional parity bit, then 1 or 2 stop bits. It sits between the TX-side FIFO's read port (registered `Data_out`, `Empty`, `rd_en`) and the pad.

## Interface
- `DATA_SIZE`, default 8: data bits per frame. Must match the FIFO width.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be ≥ 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: 1 or 2 stop bits.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_en` input 1: permits starting a new frame. It is sampled only in IDLE.
- `fifo_data` input DATA_SIZE: FIFO registered read data. It is valid the cycle after `fifo_rd_en`=1.
- `fifo_empty` input 1: FIFO Empty flag.
- `fifo_rd_en` output 1: FIFO pop strobe. It is exactly one cycle wide per word.
- `tx` output 1: serial line. Idle level is high.
- `busy` output 1: high in every state except IDLE.
- `tx_done` output 1: one-cycle pulse on the last clk of the final stop bit.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `tx_en`=1 and `fifo_empty`=0, go to FETCH. Otherwise stay in IDLE.
- FETCH: `fifo_rd_en`=1 for this cycle only. Always go to LOAD.
- LOAD:
  - Capture `fifo_data` into the shift register.
  - Compute parity as the XOR of all data bits, inverted when `PARITY_ODD`=1.
  - Clear the baud and bit counters. Go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0.
  - Shift right every CLKS_PER_BIT cycles.
  - After DATA_SIZE bits, go to PARITY if `PARITY_EN`=1, else go to STOP.
- PARITY: `tx` = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - `tx_done`=1 on the final cycle of STOP.
  - Then go to IDLE.
- `fifo_rd_en` is a decoded Moore output of FETCH. It is never asserted while `fifo_empty`=1, because FETCH is entered only when `fifo_empty`=0.
- `tx_en` deasserted mid-frame does not abort the frame. The frame completes and the FSM stays in IDLE afterwards.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Bit counter: $clog2(DATA_SIZE+1) bits.
- `tx` is driven from a flop; there is no combinational path from inputs to `tx`.
- Reset asserted at any time forces IDLE immediately, with `tx`=1, `busy`=0, `fifo_rd_en`=0, `tx_done`=0. An in-flight word is lost. A word popped in FETCH but not yet loaded is also lost.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_rd_en`=0, `tx_done`=0. All counters and the shift register are 0.
- Start latency: `fifo_empty` falls (with `tx_en`=1) in cycle t:
  - `fifo_rd_en`=1 in cycle t+1.
  - Data is loaded at the end of cycle t+2.
  - The start bit begins in cycle t+3.
- `busy` rises in cycle t+1 and falls in the first IDLE cycle after STOP.
- Frame length F = CLKS_PER_BIT × (1 + DATA_SIZE + PARITY_EN + STOP_BITS) cycles, measured from the start-bit edge.
- Back-to-back frames: the end of one frame is followed by IDLE, FETCH and LOAD, so there are exactly 3 extra high cycles before the next start bit.
- Once out of reset, the first possible `fifo_rd_en` is 1 cycle after IDLE observes `fifo_empty`=0.

## Test plan
- Reset: hold `rst_n`=0 with `fifo_empty`=0 → `tx`=1, `busy`=0, `fifo_rd_en`=0. Release `rst_n` → `fifo_rd_en` pulses on the 2nd clk edge after release.
- Single byte, 8N1 (CLKS_PER_BIT=4, `tx_en`=1), word 0xA5; `fifo_empty` falls at cycle 0:
  - `fifo_rd_en`=1 in cycle 1 only.
  - `tx`=0 in cycles 3–6.
  - Data bits 1,0,1,0,0,1,0,1 follow, each 4 cycles.
  - Stop bit high in cycles 39–42; `tx_done`=1 in cycle 42; `busy`=0 from cycle 43.
- Parity, word 0x07:
  - `PARITY_EN`=1, `PARITY_ODD`=0 → parity bit = 1.
  - `PARITY_ODD`=1 → parity bit = 0.
  - `STOP_BITS`=2 → stop period lasts 8 cycles; F = 48.
- Back-to-back, words 0x55 then 0x0F queued:
  - Exactly two `fifo_rd_en` pulses.
  - Second start bit begins at cycle 46 (3 high gap cycles, 43–45).
  - Serial bit order is correct for both words.
- `tx_en` gating:
  - `tx_en`=0 with FIFO non-empty → no `fifo_rd_en`, `tx` stays 1.
  - `tx_en` dropped in the middle of DATA → current frame completes intact, then no further pops.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3 → `tx`=1 and `busy`=0 asynchronously, with no `tx_done` pulse. After release, the next queued word is transmitted as a complete frame.

Source files
------------

// File: rtl/uart_tx_fifo_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ==== uart_tx_fifo_reader : pops words from a TX FIFO, serialises start/data/parity/stop ====
// ==== Rev 1.0                                                                            ====
module uart_tx_fifo_reader #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic [DATA_SIZE-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_SIZE + 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_LOAD   = 3'd2;
  localparam logic [2:0] c_START  = 3'd3;
  localparam logic [2:0] c_DATA   = 3'd4;
  localparam logic [2:0] c_PARITY = 3'd5;
  localparam logic [2:0] c_STOP   = 3'd6;

  localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  c_DATA_LAST = BIT_W'(DATA_SIZE - 1);
  localparam logic [BIT_W-1:0]  c_STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              c_ODD       = (PARITY_ODD != 0);

  logic [2:0]           r_state;
  logic                 r_tx;
  logic [DATA_SIZE-1:0] r_shift;
  logic                 r_parity;
  logic [BAUD_W-1:0]    r_baud;
  logic [BIT_W-1:0]     r_bit;

  logic                 w_baud_last;
  logic [BAUD_W-1:0]    w_baud_next;
  logic [DATA_SIZE-1:0] w_shift_next;

  assign w_baud_last  = (r_baud == c_BAUD_LAST);
  assign w_baud_next  = w_baud_last ? '0 : r_baud + BAUD_W'(1);
  assign w_shift_next = r_shift >> 1;

  assign fifo_rd_en = (r_state == c_FETCH);
  assign busy       = (r_state != c_IDLE);
  assign tx_done    = (r_state == c_STOP) && w_baud_last && (r_bit == c_STOP_LAST);
  assign tx         = r_tx;

  // r_tx is loaded with the level of the state being entered, so the line is always flop-driven
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_tx <= 1'b1;
          if (tx_en && !fifo_empty) r_state <= c_FETCH;
        end
        c_FETCH: r_state <= c_LOAD;
        c_LOAD: begin
          r_shift  <= fifo_data;
          r_parity <= (^fifo_data) ^ c_ODD;
          r_baud   <= '0;
          r_bit    <= '0;
          r_tx     <= 1'b0;
          r_state  <= c_START;
        end
        c_START: begin
          r_baud <= w_baud_next;
          if (w_baud_last) begin
            r_tx    <= r_shift[0];
            r_state <= c_DATA;
          end
        end
        c_DATA: begin
          r_baud <= w_baud_next;
          if (w_baud_last) begin
            r_shift <= w_shift_next;
            if (r_bit == c_DATA_LAST) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= c_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= c_STOP;
              end
            end else begin
              r_bit <= r_bit + BIT_W'(1);
              r_tx  <= w_shift_next[0];
            end
          end
        end
        c_PARITY: begin
          r_baud <= w_baud_next;
          if (w_baud_last) begin
            r_tx    <= 1'b1;
            r_state <= c_STOP;
          end
        end
        c_STOP: begin
          r_baud <= w_baud_next;
          // r_bit is reused to count stop bits
          if (w_baud_last) begin
            if (r_bit == c_STOP_LAST) begin
              r_bit   <= '0;
              r_state <= c_IDLE;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tb_uart_tx_fifo_reader : 8N1, 8E1 and 8O2 instances at 4 clks/bit ====
// ==== Rev 1.0                                                           ====
module tb_uart_tx_fifo_reader;

  localparam int D = 2;  // don't-care marker in the vector table

  typedef struct {
    int cyc;
    int a_tx, a_rd, a_busy, a_done;
    int p_tx, p_done, p_busy;
    int o_tx, o_done, o_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tx_en = 1'b1;

  // main 8N1 instance with a small FIFO model
  logic [7:0] mem_a [0:15];
  int         wp_a = 0;
  int         rp_a = 0;
  logic [7:0] data_a = 8'h00;
  logic       empty_a;
  logic       rd_a, tx_a, busy_a, done_a;

  // parity instances each hold a single 0x07 word
  int         wr_p = 0, rd_cnt_p = 0, wr_o = 0, rd_cnt_o = 0;
  logic [7:0] data_po = 8'h07;
  logic       empty_p, empty_o;
  logic       rd_p, tx_p, busy_p, done_p;
  logic       rd_o, tx_o, busy_o, done_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int n_done   = 0;
  int n_frames = 0;
  logic [7:0] exp_q [$];
  vec_t       tbl [$];

  assign empty_a = (wp_a == rp_a);
  assign empty_p = (wr_p == rd_cnt_p);
  assign empty_o = (wr_o == rd_cnt_o);

  always #5 clk = ~clk;

  uart_tx_fifo_reader #(.DATA_SIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_data(data_a), .fifo_empty(empty_a),
    .fifo_rd_en(rd_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a));

  uart_tx_fifo_reader #(.DATA_SIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_data(data_po), .fifo_empty(empty_p),
    .fifo_rd_en(rd_p), .tx(tx_p), .busy(busy_p), .tx_done(done_p));

  uart_tx_fifo_reader #(.DATA_SIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_data(data_po), .fifo_empty(empty_o),
    .fifo_rd_en(rd_o), .tx(tx_o), .busy(busy_o), .tx_done(done_o));

  always @(posedge clk) begin
    if (rd_a) begin
      data_a <= mem_a[rp_a];
      rp_a   <= rp_a + 1;
      n_pops <= n_pops + 1;
    end
    if (rd_p) rd_cnt_p <= rd_cnt_p + 1;
    if (rd_o) rd_cnt_o <= rd_cnt_o + 1;
    if (done_a) n_done <= n_done + 1;
  end

  task automatic chk(input string nm, input logic act, input int expv);
    if (expv != D) begin
      n_checks++;
      if (act !== expv[0]) begin
        n_errors++;
        $display("FAIL %s: got %0b expected %0d at %0t", nm, act, expv, $time);
      end
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit scored);
    mem_a[wp_a] = d;
    wp_a++;
    if (scored) exp_q.push_back(d);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Receiver scoreboard for dut_a: samples mid-bit, pops the expected word at the stop bit
  int         mon_t = 0;
  bit         mon_on = 1'b0;
  logic [7:0] mon_byte = 8'h00;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      mon_on = 1'b0;
    end else begin
      if (!mon_on && tx_a == 1'b0) begin
        mon_on = 1'b1;
        mon_t  = 0;
      end
      if (mon_on) begin
        if (mon_t >= 6 && mon_t <= 34 && ((mon_t - 6) % 4) == 0)
          mon_byte[(mon_t - 6) / 4] = tx_a;
        if (mon_t == 38) begin
          chk("stop_bit", tx_a, 1);
          n_frames++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_unexpected: got %02h expected none", mon_byte);
          end else begin
            chk_int("frame_data", int'(mon_byte), int'(exp_q.pop_front()));
          end
          mon_on = 1'b0;
        end
        mon_t++;
      end
    end
  end

  initial begin
    int pops0, done0;
    // cyc | a: tx rd busy done | p: tx done busy | o: tx done busy
    tbl.push_back('{ 0, 1,0,0,0, 1,0,0, 1,0,0});
    tbl.push_back('{ 1, 1,1,1,0, 1,0,1, 1,0,1});
    tbl.push_back('{ 2, 1,0,1,0, 1,0,1, 1,0,1});
    tbl.push_back('{ 3, 0,0,1,0, 0,0,1, 0,0,1});
    tbl.push_back('{ 6, 0,0,1,0, 0,D,D, 0,D,D});
    tbl.push_back('{ 7, 1,0,1,0, 1,D,D, 1,D,D});
    tbl.push_back('{11, 0,D,D,D, 1,D,D, 1,D,D});
    tbl.push_back('{15, 1,D,D,D, 1,D,D, 1,D,D});
    tbl.push_back('{19, 0,D,D,D, 0,D,D, 0,D,D});
    tbl.push_back('{23, 0,D,D,D, 0,D,D, 0,D,D});
    tbl.push_back('{27, 1,D,D,D, 0,D,D, 0,D,D});
    tbl.push_back('{31, 0,D,D,D, 0,D,D, 0,D,D});
    tbl.push_back('{38, 1,0,1,0, 0,D,D, 0,D,D});
    tbl.push_back('{39, 1,0,1,0, 1,0,1, 0,0,1});
    tbl.push_back('{42, 1,0,1,1, 1,0,1, 0,0,1});
    tbl.push_back('{43, 1,0,0,0, 1,0,1, 1,0,1});
    tbl.push_back('{46, 1,0,0,0, 1,1,1, 1,0,1});
    tbl.push_back('{47, D,D,D,D, 1,0,0, 1,0,1});
    tbl.push_back('{50, 1,0,0,0, 1,0,0, 1,1,1});
    tbl.push_back('{51, 1,0,0,0, 1,0,0, 1,0,0});

    // reset held with non-empty FIFOs
    #1 rst_n = 1'b0;
    push(8'hA5, 1'b1);
    wr_p = 1;
    wr_o = 1;
    repeat (3) next_cycle();
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_rd_en", rd_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy_p", busy_p, 0);
    chk("rst_tx_o", tx_o, 1);

    // release: cycle 0 is the first IDLE cycle seeing a non-empty FIFO
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k <= 52; k++) begin
      if (k > 0) next_cycle();
      foreach (tbl[i]) begin
        if (tbl[i].cyc == k) begin
          chk($sformatf("a_tx@%0d", k),   tx_a,   tbl[i].a_tx);
          chk($sformatf("a_rd@%0d", k),   rd_a,   tbl[i].a_rd);
          chk($sformatf("a_busy@%0d", k), busy_a, tbl[i].a_busy);
          chk($sformatf("a_done@%0d", k), done_a, tbl[i].a_done);
          chk($sformatf("p_tx@%0d", k),   tx_p,   tbl[i].p_tx);
          chk($sformatf("p_done@%0d", k), done_p, tbl[i].p_done);
          chk($sformatf("p_busy@%0d", k), busy_p, tbl[i].p_busy);
          chk($sformatf("o_tx@%0d", k),   tx_o,   tbl[i].o_tx);
          chk($sformatf("o_done@%0d", k), done_o, tbl[i].o_done);
          chk($sformatf("o_busy@%0d", k), busy_o, tbl[i].o_busy);
        end
      end
    end
    chk_int("pops_single", n_pops, 1);

    // back-to-back 0x55 then 0x0F
    pops0 = n_pops;
    push(8'h55, 1'b1);
    push(8'h0F, 1'b1);
    for (int k = 0; k <= 90; k++) begin
      if (k > 0) next_cycle();
      if (k == 42) chk("b2b_done1", done_a, 1);
      if (k == 43) chk("b2b_gap43_busy", busy_a, 0);
      if (k >= 43 && k <= 45) chk($sformatf("b2b_gap_tx@%0d", k), tx_a, 1);
      if (k == 44) chk("b2b_rd2", rd_a, 1);
      if (k == 46) chk("b2b_start2", tx_a, 0);
      if (k == 85) chk("b2b_done2", done_a, 1);
      if (k == 86) chk("b2b_idle", busy_a, 0);
    end
    chk_int("b2b_pops", n_pops - pops0, 2);

    // tx_en low with data waiting
    tx_en = 1'b0;
    pops0 = n_pops;
    push(8'h3C, 1'b0);
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      chk("gate_tx", tx_a, 1);
      chk("gate_rd", rd_a, 0);
    end
    chk_int("gate_pops", n_pops - pops0, 0);

    // enable, then drop tx_en mid-DATA: frame completes, 0xC3 stays queued
    exp_q.push_back(8'h3C);
    push(8'hC3, 1'b0);
    tx_en = 1'b1;
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) next_cycle();
      if (k == 20) tx_en = 1'b0;
      if (k == 42) chk("drop_done", done_a, 1);
      if (k > 43) chk($sformatf("drop_idle_tx@%0d", k), tx_a, 1);
    end
    chk("drop_busy", busy_a, 0);
    chk_int("drop_pops", n_pops - pops0, 1);

    // reset during DATA bit 3 of 0xC3, then 0x96 must go out whole
    exp_q.push_back(8'hC3);
    push(8'h96, 1'b1);
    tx_en = 1'b1;
    for (int k = 1; k <= 20; k++) next_cycle();
    done0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    void'(exp_q.pop_front());
    repeat (2) next_cycle();
    chk_int("mid_rst_no_done", n_done, done0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 50; k++) next_cycle();
    chk_int("post_rst_done", n_done, done0 + 1);
    chk("post_rst_busy", busy_a, 0);

    chk_int("frames_seen", n_frames, 5);
    chk_int("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
